alu_seq_ctrl: RTL and testbench

Parametrised next-generation ALU control and execute block for the multi-cycle/pipelined datapaths. It decodes the 2-bit ALUOp and 3-bit function code, executes single-cycle operations with a one-cycle registered result, and adds iterative unsigned multiply and divide with a valid/ready handshake that stalls the issuing stage. It sits between the decode/ID-EX register and the EX/MEM register and replaces the purely combinational control decode plus ALU pair.

---
 rtl/alu_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// ALU control decode and execute stage: registered single-cycle ops plus iterative
// unsigned shift-add multiply and restoring divide behind a valid/ready handshake.
module alu_seq_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [2:0]       FuncCode,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_by_zero,
    output logic             busy
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;
    // Encoding matches the R-type function code so decode is a direct cast.
    typedef enum logic [2:0] {OpAdd, OpMul, OpSub, OpDiv, OpAnd, OpOr, OpSlt, OpNor} op_e;

    state_e             state_q, state_d;
    op_e                op;
    logic               accept, last;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d, hi_q, hi_d, alu_res;
    logic               zero_q, zero_d, dbz_q, dbz_d, valid_q, valid_d;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_diff, rem_next;
    logic               qbit;

    always_comb begin
        unique case (ALUOp)
            2'b01:   op = OpSub;
            2'b10:   op = op_e'(FuncCode);
            default: op = OpAdd;
        endcase
    end

    always_comb begin
        case (op)
            OpAdd:   alu_res = src_a + src_b;
            OpSub:   alu_res = src_a - src_b;
            OpAnd:   alu_res = src_a & src_b;
            OpOr:    alu_res = src_a | src_b;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OpNor:   alu_res = ~(src_a | src_b);
            default: alu_res = {WIDTH{1'b0}};
        endcase
    end

    assign accept = in_valid && in_ready;
    assign last   = (cnt_q == CntW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && op == OpMul)                           state_d = StMul;
                else if (accept && op == OpDiv && src_b != '0)       state_d = StDiv;
            end
            StMul, StDiv: if (last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = (state_q == StIdle);
        busy     = (state_q != StIdle);
    end

    // Multiply: {hi, multiplier} shifts right, multiplicand added into hi.
    // Divide: {remainder, dividend} shifts left, quotient bits enter at the bottom.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        qbit      = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        rem_next  = qbit ? div_diff : div_shift[WIDTH-1:0];
    end

    always_comb begin
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        dbz_d    = dbz_q;
        valid_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d = '0;
                    if (op == OpMul) begin
                        acc_d  = {{WIDTH{1'b0}}, src_b};
                        opnd_d = src_a;
                    end else if (op == OpDiv && src_b != '0) begin
                        acc_d  = {{WIDTH{1'b0}}, src_a};
                        opnd_d = src_b;
                    end else if (op == OpDiv) begin
                        result_d = {WIDTH{1'b1}};
                        hi_d     = src_a;
                        zero_d   = 1'b0;
                        dbz_d    = 1'b1;
                        valid_d  = 1'b1;
                    end else begin
                        result_d = alu_res;
                        hi_d     = {WIDTH{1'b0}};
                        zero_d   = (alu_res == '0);
                        dbz_d    = 1'b0;
                        valid_d  = 1'b1;
                    end
                end
            end
            StMul, StDiv: begin
                cnt_d = cnt_q + CntW'(1);
                if (state_q == StMul) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                else                  acc_d = {rem_next, acc_q[WIDTH-2:0], qbit};
                if (last) begin
                    cnt_d    = '0;
                    result_d = acc_d[WIDTH-1:0];
                    hi_d     = acc_d[2*WIDTH-1:WIDTH];
                    zero_d   = (acc_d[WIDTH-1:0] == '0);
                    dbz_d    = 1'b0;
                    valid_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            dbz_q    <= dbz_d;
            valid_q  <= valid_d;
        end
    end

    assign out_valid   = valid_q;
    assign result      = result_q;
    assign result_hi   = hi_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl at WIDTH=32 and WIDTH=8.
module tb_alu_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        in_valid, in_ready, out_valid, zero, div_by_zero, busy;
    logic [1:0]  aluop;
    logic [2:0]  func;
    logic [31:0] a, b, result, result_hi;

    logic        in_valid8, in_ready8, out_valid8, zero8, dbz8, busy8;
    logic [1:0]  aluop8;
    logic [2:0]  func8;
    logic [7:0]  a8, b8, result8, result_hi8;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        d;
        int          due;
        string       nm;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;

    alu_seq_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(aluop), .FuncCode(func), .src_a(a), .src_b(b),
        .out_valid(out_valid), .result(result), .result_hi(result_hi),
        .zero(zero), .div_by_zero(div_by_zero), .busy(busy)
    );

    alu_seq_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .ALUOp(aluop8), .FuncCode(func8), .src_a(a8), .src_b(b8),
        .out_valid(out_valid8), .result(result8), .result_hi(result_hi8),
        .zero(zero8), .div_by_zero(dbz8), .busy(busy8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q32.size() == 0) begin
                chk("spurious_valid32", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk({e.nm, "_res"}, 64'(result), 64'(e.res));
                chk({e.nm, "_hi"}, 64'(result_hi), 64'(e.hi));
                chk({e.nm, "_flags"}, 64'({zero, div_by_zero}), 64'({e.z, e.d}));
                chk({e.nm, "_lat"}, 64'(cyc), 64'(e.due));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid8) begin
            if (q8.size() == 0) begin
                chk("spurious_valid8", 64'(out_valid8), 64'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk({e.nm, "_res"}, 64'(result8), 64'(e.res[7:0]));
                chk({e.nm, "_hi"}, 64'(result_hi8), 64'(e.hi[7:0]));
                chk({e.nm, "_flags"}, 64'({zero8, dbz8}), 64'({e.z, e.d}));
                chk({e.nm, "_lat"}, 64'(cyc), 64'(e.due));
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [1:0] op, input logic [2:0] fn,
                         input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] er, input logic [31:0] eh,
                         input logic ez, input logic ed, input int lat, input string nm);
        exp_t e;
        int   g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) chk({nm, "_ready_timeout"}, 64'(in_ready), 64'd1);
        aluop = op; func = fn; a = xa; b = xb; in_valid = 1'b1;
        e.res = er; e.hi = eh; e.z = ez; e.d = ed; e.due = cyc + lat; e.nm = nm;
        q32.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic issue8(input logic [1:0] op, input logic [2:0] fn,
                          input logic [7:0] xa, input logic [7:0] xb,
                          input logic [7:0] er, input logic [7:0] eh,
                          input logic ez, input logic ed, input int lat, input string nm);
        exp_t e;
        int   g = 0;
        while (!in_ready8 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready8) chk({nm, "_ready_timeout"}, 64'(in_ready8), 64'd1);
        aluop8 = op; func8 = fn; a8 = xa; b8 = xb; in_valid8 = 1'b1;
        e.res = {24'd0, er}; e.hi = {24'd0, eh}; e.z = ez; e.d = ed; e.due = cyc + lat; e.nm = nm;
        q8.push_back(e);
        @(negedge clk);
        in_valid8 = 1'b0;
    endtask

    initial begin
        int n;
        in_valid = 1'b0; aluop = '0; func = '0; a = '0; b = '0;
        in_valid8 = 1'b0; aluop8 = '0; func8 = '0; a8 = '0; b8 = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", 64'({in_ready, out_valid, busy, zero, div_by_zero}), 64'(5'b10000));
        chk("rst_res", 64'({result, result_hi}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'b10, 3'b000, 32'd5, 32'd7, 32'd12, 32'd0, 1'b0, 1'b0, 1, "add");
        issue(2'b10, 3'b010, 32'd3, 32'd3, 32'd0, 32'd0, 1'b1, 1'b0, 1, "sub_zero");
        issue(2'b10, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1, "slt_neg");
        issue(2'b01, 3'b000, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1, "beq_wrap");
        issue(2'b00, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 1'b0, 1, "lw_add_wrap");
        issue(2'b10, 3'b100, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 32'd0, 1'b0, 1'b0, 1,
              "and");
        issue(2'b10, 3'b101, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 32'd0, 1'b0, 1'b0, 1,
              "or");
        issue(2'b10, 3'b111, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1, "nor_ones");
        issue(2'b10, 3'b111, 32'hFFFF_0000, 32'h0000_FFFF, 32'd0, 32'd0, 1'b1, 1'b0, 1,
              "nor_zero");
        issue(2'b10, 3'b110, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b0, 1,
              "slt_max_min");
        issue(2'b11, 3'b010, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1, "op11_add");

        issue(2'b10, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE,
              1'b0, 1'b0, 33, "mul_max");
        chk("mul_busy", 64'({in_ready, busy}), 64'(2'b01));
        n = 0;
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("mul_ready_low", 64'(n), 64'd32);

        // Accepted in the same cycle the multiply result is presented.
        issue(2'b10, 3'b011, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33, "div_100_7");
        issue(2'b10, 3'b011, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b1, 1, "div_by_0");
        issue(2'b10, 3'b000, 32'd1, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1, "add_after_dbz");

        issue(2'b10, 3'b001, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd1, 1'b1, 1'b0, 33,
              "mul_2pow32");
        aluop = 2'b10; func = 3'b000; a = 32'd1; b = 32'd1; in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        issue(2'b10, 3'b011, 32'd5, 32'd9, 32'd0, 32'd5, 1'b1, 1'b0, 33, "div_5_9");

        issue(2'b10, 3'b001, 32'd3, 32'd3, 32'd9, 32'd0, 1'b0, 1'b0, 33, "mul_abort");
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        q32.delete();
        chk("abort_ctl", 64'({in_ready, out_valid, busy, zero, div_by_zero}), 64'(5'b10000));
        chk("abort_res", 64'({result, result_hi}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_idle", 64'({in_ready, busy}), 64'(2'b10));
        issue(2'b11, 3'b000, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1, "add_after_abort");

        issue8(2'b10, 3'b001, 8'hFF, 8'h02, 8'hFE, 8'h01, 1'b0, 1'b0, 9, "mul8");
        issue8(2'b10, 3'b011, 8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 1'b0, 9, "div8");
        issue8(2'b10, 3'b011, 8'h80, 8'h00, 8'hFF, 8'h80, 1'b0, 1'b1, 1, "div8_by_0");
        issue8(2'b10, 3'b110, 8'h80, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1, "slt8");

        repeat (20) @(negedge clk);
        chk("q32_drained", 64'(q32.size()), 64'd0);
        chk("q8_drained", 64'(q8.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1);
    end
endmodule
